// File: rtl/sign_mag_add.sv
// Registered N-bit sign-magnitude adder.
// Purpose : sums two sign-magnitude operands (MSB = sign, 1 = negative) and
//           registers the result with one clock of latency. The magnitude
//           wraps on overflow, and an overflow flag is raised alongside it.
//           Negative zero is never produced on the output.
// Ports   : clk   - system clock, rising edge
//           reset - asynchronous active-high reset, clears sum/ovf
//           a, b  - N-bit sign-magnitude operands
//           sum   - registered N-bit sign-magnitude result
//           ovf   - registered flag, true magnitude did not fit in N-1 bits
module sign_mag_add #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         ovf
);

    localparam int unsigned MW = N - 1;

    logic [MW-1:0] mag_a;
    logic [MW-1:0] mag_b;
    logic [MW-1:0] max_mag;
    logic [MW-1:0] min_mag;
    logic          max_sgn;
    logic [N-1:0]  mag_sum;
    logic [MW-1:0] res_mag;
    logic          res_sgn;

    logic [N-1:0]  sum_d, sum_q;
    logic          ovf_d, ovf_q;

    // Order operands by magnitude; ties go to b
    always_comb begin
        mag_a = a[MW-1:0];
        mag_b = b[MW-1:0];
        if (mag_a > mag_b) begin
            max_mag = mag_a;
            min_mag = mag_b;
            max_sgn = a[N-1];
        end else begin
            max_mag = mag_b;
            min_mag = mag_a;
            max_sgn = b[N-1];
        end
    end

    // Add or subtract magnitudes, then normalize a zero result to +0
    always_comb begin
        mag_sum = N'(max_mag) + N'(min_mag);
        res_mag = '0;
        res_sgn = 1'b0;
        ovf_d   = 1'b0;
        sum_d   = '0;
        if (a[N-1] == b[N-1]) begin
            res_mag = mag_sum[MW-1:0];
            res_sgn = a[N-1];
            ovf_d   = mag_sum[MW];
        end else begin
            // max_mag >= min_mag, so this never goes negative
            res_mag = max_mag - min_mag;
            res_sgn = max_sgn;
        end
        if (res_mag != '0) begin
            sum_d = {res_sgn, res_mag};
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            ovf_q <= ovf_d;
        end
    end

    assign sum = sum_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_sign_mag_add.sv
// Testbench for sign_mag_add: directed vector table at N=4, hand-written
// reset and N=8 corner sequences, and back-to-back random pairs checked
// against an integer reference model for both N=4 and N=8.
module tb_sign_mag_add;

    logic       clk;
    logic       reset;
    logic [3:0] a4, b4, sum4;
    logic       ovf4;
    logic [7:0] a8, b8, sum8;
    logic       ovf8;

    int checks;
    int errors;

    sign_mag_add #(.N(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .a     (a4),
        .b     (b4),
        .sum   (sum4),
        .ovf   (ovf4)
    );

    sign_mag_add #(.N(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .a     (a8),
        .b     (b8),
        .sum   (sum8),
        .ovf   (ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sum;
        logic       ovf;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Reference: convert to signed integers, add, then fold back to sign-magnitude
    function automatic logic [8:0] model(input int n, input logic [7:0] a, input logic [7:0] b);
        int mmax, ma, mb, va, vb, t, at, rm;
        logic [7:0] s;
        logic o;
        mmax = (1 << (n - 1)) - 1;
        ma = int'(a) & mmax;
        mb = int'(b) & mmax;
        va = a[n-1] ? -ma : ma;
        vb = b[n-1] ? -mb : mb;
        t  = va + vb;
        at = (t < 0) ? -t : t;
        o  = (at > mmax);
        rm = at % (mmax + 1);
        s  = '0;
        if (rm != 0) begin
            s = 8'(rm);
            if (t < 0) s[n-1] = 1'b1;
        end
        return {o, s};
    endfunction

    initial begin
        logic [8:0] e4, e8;
        checks = 0;
        errors = 0;
        vecs[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[1]  = '{4'b0100, 4'b0001, 4'b0101, 1'b0};
        vecs[2]  = '{4'b1001, 4'b1010, 4'b1011, 1'b0};
        vecs[3]  = '{4'b1100, 4'b0010, 4'b1010, 1'b0};
        vecs[4]  = '{4'b1010, 4'b0011, 4'b0001, 1'b0};
        vecs[5]  = '{4'b0111, 4'b0010, 4'b0001, 1'b1};
        vecs[6]  = '{4'b1111, 4'b1010, 4'b1001, 1'b1};
        vecs[7]  = '{4'b0100, 4'b0100, 4'b0000, 1'b1};
        vecs[8]  = '{4'b0010, 4'b1010, 4'b0000, 1'b0};
        vecs[9]  = '{4'b1010, 4'b0010, 4'b0000, 1'b0};
        vecs[10] = '{4'b1000, 4'b0000, 4'b0000, 1'b0};
        vecs[11] = '{4'b1000, 4'b1000, 4'b0000, 1'b0};
        vecs[12] = '{4'b0000, 4'b1011, 4'b1011, 1'b0};
        vecs[13] = '{4'b1111, 4'b1111, 4'b1110, 1'b1};
        vecs[14] = '{4'b0011, 4'b1111, 4'b1100, 1'b0};

        reset = 1'b1;
        a4 = 4'b0111; b4 = 4'b0010;
        a8 = 8'h7F;   b8 = 8'h01;
        #1;
        chk("reset_sum4", 8'(sum4), 8'h00);
        chk("reset_ovf4", 8'(ovf4), 8'h00);
        @(posedge clk); #1;
        chk("reset_hold_sum4", 8'(sum4), 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Directed table, one vector per cycle
        foreach (vecs[i]) begin
            @(negedge clk);
            a4 = vecs[i].a;
            b4 = vecs[i].b;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_sum", i), 8'(sum4), 8'(vecs[i].sum));
            chk($sformatf("vec%0d_ovf", i), 8'(ovf4), 8'(vecs[i].ovf));
        end

        // N=8 corners: +127 + +1 wraps to zero with ovf; -127 + +127 is +0
        @(negedge clk);
        a8 = 8'h7F; b8 = 8'h01;
        @(posedge clk); #1;
        chk("n8_wrap_sum", sum8, 8'h00);
        chk("n8_wrap_ovf", 8'(ovf8), 8'h01);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h7F;
        @(posedge clk); #1;
        chk("n8_cancel_sum", sum8, 8'h00);
        chk("n8_cancel_ovf", 8'(ovf8), 8'h00);

        // Mid-run reset clears at once, and the pending result is discarded
        @(negedge clk);
        a4 = 4'b0111; b4 = 4'b0010;
        @(posedge clk); #1;
        chk("pre_reset_sum", 8'(sum4), 8'b0001);
        chk("pre_reset_ovf", 8'(ovf4), 8'h01);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_sum", 8'(sum4), 8'h00);
        chk("async_reset_ovf", 8'(ovf4), 8'h00);
        @(posedge clk); #1;
        chk("reset_edge_sum", 8'(sum4), 8'h00);
        @(negedge clk);
        reset = 1'b0;
        a4 = 4'b0100; b4 = 4'b0001;
        @(posedge clk); #1;
        chk("post_reset_sum", 8'(sum4), 8'b0101);

        // Back-to-back random pairs, both widths
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            e4 = model(4, 8'(a4), 8'(b4));
            e8 = model(8, a8, b8);
            @(posedge clk); #1;
            chk($sformatf("rnd4_%0d a=%b b=%b sum", i, a4, b4), 8'(sum4), e4[7:0]);
            chk($sformatf("rnd4_%0d ovf", i), 8'(ovf4), 8'(e4[8]));
            chk($sformatf("rnd8_%0d a=%h b=%h sum", i, a8, b8), sum8, e8[7:0]);
            chk($sformatf("rnd8_%0d ovf", i), 8'(ovf8), 8'(e8[8]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sign_mag_add.md
Name: sign_mag_add

Overview:
- Registered N-bit sign-magnitude adder.
- MSB is the sign (1 = negative); the lower N-1 bits are the unsigned magnitude.
- Sits in the datapath wherever two sign-magnitude operands must be summed.
- Result is registered with one clock of latency and carries an overflow flag for the truncated magnitude.

Parameters:
- N, 4, total operand/result width including sign bit (N >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- a  input  N  operand A; a[N-1] sign, a[N-2:0] magnitude.
- b  input  N  operand B; same format as a.
- sum  output  N  registered sign-magnitude result.
- ovf  output  1  registered flag: the true magnitude did not fit in N-1 bits.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset); no other clock or reset domain.
- Reset: while reset=1, sum=0 and ovf=0 immediately, independent of clk. Registers load normally from the first rising edge after release.
- Latency: a/b sampled on each rising edge; sum/ovf reflect those inputs after that edge (1 cycle). Fully pipelined, new operands accepted every cycle, no handshake.
- Magnitude compare:
  - mag_a = a[N-2:0], mag_b = b[N-2:0].
  - If mag_a > mag_b then max = a, min = b; otherwise (including equal) max = b, min = a.
- Same signs:
  - Compute mag_sum = max_mag + min_mag at N bits wide.
  - Result magnitude = mag_sum[N-2:0] (wrap-around truncation).
  - Result sign = common sign.
  - ovf = mag_sum[N-1].
- Different signs:
  - Result magnitude = max_mag - min_mag (never negative).
  - Result sign = max sign.
  - ovf = 0.
- Zero normalization: if the result magnitude is 0, sum is forced to all-zero (sign 0). Negative zero is never produced, including after an overflow wrap to magnitude 0.
- Negative-zero inputs (sign=1, magnitude 0) are accepted and treated as magnitude 0 per the rules above.
- Purely unsigned arithmetic internally. No saturation: overflow wraps, with ovf asserted.
- Reset asserted mid-stream: outputs clear asynchronously; the pending result is discarded.

Test Plan:
- Reset, then a=0000, b=0000 -> sum=0000, ovf=0; assert reset mid-run -> sum=0000 at once, no clk edge needed.
- Same-sign: a=0100 (+4), b=0001 (+1) -> sum=0101, ovf=0; a=1001 (-1), b=1010 (-2) -> sum=1011 (-3), ovf=0.
- Mixed-sign: a=1100 (-4), b=0010 (+2) -> sum=1010 (-2); a=1010 (-2), b=0011 (+3) -> sum=0001 (+1); ovf=0 for both.
- Overflow wrap:
  - a=0111 (+7), b=0010 (+2) -> sum=0001, ovf=1.
  - a=1111 (-7), b=1010 (-2) -> sum=1001, ovf=1.
  - a=0100, b=0100 -> sum=0000 (zero normalized), ovf=1.
- Equal magnitudes / zero:
  - a=0010, b=1010 -> sum=0000; a=1010, b=0010 -> sum=0000 (no negative zero).
  - a=1000, b=0000 -> sum=0000.
- Pipelining: change a/b every cycle over 16 random pairs for N=4 and N=8 -> each sum/ovf matches a reference model exactly one cycle later.
